// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and byte-enable helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS0 = 2'd1,
    ACCESS1 = 2'd2
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Enables span two words: [3:0] for the addressed word, [7:4] for the next one.
  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [7:0] m;
    case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0F;
      default: m = 8'h00;
    endcase
    return m << lane;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store shift and byte enables for both beats, load gather and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [31:0] wd_lo,
  output logic [31:0] wd_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] rdata
);

  logic [5:0]  sh;
  logic [63:0] wshift;
  logic [31:0] gather;

  assign sh             = {1'b0, lane, 3'b000};
  assign wshift         = {32'd0, wdata} << sh;
  assign {wd_hi, wd_lo} = wshift;
  assign {be_hi, be_lo} = byte_en(size, lane);
  assign gather         = 32'({rd_hi, rd_lo} >> sh);

  always_comb begin
    rdata = gather;
    case (size)
      SIZE_B:  rdata = {{24{~is_unsigned & gather[7]}}, gather[7:0]};
      SIZE_H:  rdata = {{16{~is_unsigned & gather[15]}}, gather[15:0]};
      default: rdata = gather;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder in front of the on-chip data RAM.
// Define DMEM_MISALIGN_EN to split word-crossing accesses into two beats; otherwise they are errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_memrw,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // every request yields exactly one rsp_valid pulse, which cannot be stalled.

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [33:0] LIMIT = 34'(DEPTH_WORDS) << 2;

  state_t          state;
  logic [31:0]     ram [DEPTH_WORDS];
  logic            memrw_q, uns_q, err_q;
  logic [1:0]      size_q, lane_q;
  logic [AW-1:0]   idx_q, idx_nx;
  logic [31:0]     wdata_q;

  logic [31:0]     off;
  logic [2:0]      nbytes;
  logic [33:0]     end_sum;
  logic            crosses, base_err, req_err;

  logic [31:0]     rd_lo, rd_hi, wd_lo, wd_hi, ld_data;
  logic [3:0]      be_lo, be_hi;

  assign req_ready = (state == IDLE) && !reset;
  assign dbg_state = state;

  assign off      = req_addr - BASE_ADDR;
  assign nbytes   = size_bytes(req_size);
  assign end_sum  = {2'b00, off} + 34'(nbytes);
  assign crosses  = ({2'b00, off[1:0]} + {1'b0, nbytes}) > 4'd4;
  assign base_err = (req_size == 2'b11) || (req_addr < BASE_ADDR) || (end_sum > LIMIT);
  assign idx_nx   = idx_q + AW'(1);

`ifdef DMEM_MISALIGN_EN
  logic        split_q;
  logic [31:0] lo_q;

  assign req_err = base_err;
  assign rd_lo   = (state == ACCESS1) ? lo_q : ram[idx_q];
  assign rd_hi   = ram[idx_nx];
`else
  assign req_err = base_err || crosses;
  assign rd_lo   = ram[idx_q];
  assign rd_hi   = '0;
  wire unused_hi = ^{wd_hi, be_hi, idx_nx};
`endif

  dmem_lane_align u_align (
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rd_lo       (rd_lo),
    .rd_hi       (rd_hi),
    .wd_lo       (wd_lo),
    .wd_hi       (wd_hi),
    .be_lo       (be_lo),
    .be_hi       (be_hi),
    .rdata       (ld_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            memrw_q <= req_memrw;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= off[1:0];
            idx_q   <= off[AW+1:2];
            wdata_q <= req_wdata;
            err_q   <= req_err;
`ifdef DMEM_MISALIGN_EN
            split_q <= crosses;
`endif
            state   <= ACCESS0;
          end
        end
        ACCESS0: begin
          // An error request spends this cycle as a bubble: no RAM access at all.
          if (err_q) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= IDLE;
          end
`ifdef DMEM_MISALIGN_EN
          else if (split_q) begin
            lo_q  <= ram[idx_q];
            state <= ACCESS1;
          end
`endif
          else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= memrw_q ? 32'd0 : ld_data;
            state     <= IDLE;
          end
        end
`ifdef DMEM_MISALIGN_EN
        ACCESS1: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= memrw_q ? 32'd0 : ld_data;
          state     <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset; a reset edge suppresses any write still in flight.
  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS0 && !err_q && memrw_q) begin
      for (int b = 0; b < 4; b++)
        if (be_lo[b]) ram[idx_q][8*b +: 8] <= wd_lo[8*b +: 8];
    end
`ifdef DMEM_MISALIGN_EN
    if (!reset && state == ACCESS1 && memrw_q) begin
      for (int b = 0; b < 4; b++)
        if (be_hi[b]) ram[idx_nx][8*b +: 8] <= wd_hi[8*b +: 8];
    end
`endif
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, scoreboard queue, reset and back-to-back sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] B = 32'h0100_0000;
`ifdef DMEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_memrw = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_memrw    (req_memrw),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // {err, rdata, due cycle}
  logic [64:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    logic [64:0] e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[63:32]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[64]});
        chk("rsp_cycle", 32'(cyc), e[31:0]);
      end
    end else if (exp_q.size() != 0 && cyc > int'(exp_q[0][31:0])) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp: got none expected one by cycle %0d", e[31:0]);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic rw, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic e, input int lat,
                      output int acc);
    int n = 0;
    @(negedge clock);
    req_valid    = 1'b1;
    req_memrw    = rw;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected 1 within 20 cycles");
      acc = -1;
    end else begin
      acc = cyc;
      exp_q.push_back({e, rd, 32'(cyc + lat)});
    end
    @(posedge clock);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rw, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic e, input int lat);
    vec_t v;
    v.rw = rw; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
    v.rd = rd; v.err = e; v.lat = lat;
    vecs.push_back(v);
  endfunction

  logic [31:0] model[8];
  int acc, acc_prev;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clock);
    #1;
    chk("reset_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    reset = 1'b0;

    // ---------------- vector table ----------------
    add(1, SIZE_W, 0, B + 32'h10,  32'hDEADBEEF, 32'h0,        0, 2);
    add(0, SIZE_W, 0, B + 32'h10,  32'h0,        32'hDEADBEEF, 0, 2);
    add(1, SIZE_B, 0, B + 32'h13,  32'h00000080, 32'h0,        0, 2);
    add(0, SIZE_B, 0, B + 32'h13,  32'h0,        32'hFFFFFF80, 0, 2);
    add(0, SIZE_B, 1, B + 32'h13,  32'h0,        32'h00000080, 0, 2);
    add(0, SIZE_W, 0, B + 32'h10,  32'h0,        32'h80ADBEEF, 0, 2);
    add(1, SIZE_W, 0, B + 32'h10,  32'h44332211, 32'h0,        0, 2);
    add(1, SIZE_W, 0, B + 32'h14,  32'h88776655, 32'h0,        0, 2);
    add(0, SIZE_W, 0, B + 32'h12,  32'h0,        MIS ? 32'h66554433 : 32'h0, !MIS, MIS ? 3 : 2);
    add(0, SIZE_H, 0, B + 32'h12,  32'h0,        32'h00004433, 0, 2);
    add(0, SIZE_H, 0, B + 32'h16,  32'h0,        32'hFFFF8877, 0, 2);
    add(0, SIZE_H, 1, B + 32'h16,  32'h0,        32'h00008877, 0, 2);
    add(1, SIZE_W, 0, B + 32'hFFC, 32'hCAFEF00D, 32'h0,        0, 2);
    add(1, SIZE_W, 0, B + 32'h1000, 32'h12345678, 32'h0,       1, 2);
    add(1, 2'b11,  0, B + 32'hFFC, 32'h11111111, 32'h0,        1, 2);
    add(0, SIZE_W, 0, B + 32'hFFC, 32'h0,        32'hCAFEF00D, 0, 2);
    add(0, SIZE_W, 0, B + 32'hFFE, 32'h0,        32'h0,        1, 2);
    add(0, SIZE_B, 1, B + 32'hFFF, 32'h0,        32'h000000CA, 0, 2);
    add(0, SIZE_W, 0, B - 32'h4,   32'h0,        32'h0,        1, 2);
    add(1, SIZE_W, 0, B + 32'h20,  32'h0,        32'h0,        0, 2);
    add(1, SIZE_W, 0, B + 32'h24,  32'h0,        32'h0,        0, 2);
    add(1, SIZE_H, 0, B + 32'h21,  32'h0000BEEF, 32'h0,        0, 2);
    add(0, SIZE_W, 0, B + 32'h20,  32'h0,        32'h00BEEF00, 0, 2);
    add(1, SIZE_W, 0, B + 32'h23,  32'hAABBCCDD, 32'h0,        !MIS, MIS ? 3 : 2);
    add(0, SIZE_W, 0, B + 32'h20,  32'h0,        MIS ? 32'hDDBEEF00 : 32'h00BEEF00, 0, 2);
    add(0, SIZE_W, 0, B + 32'h24,  32'h0,        MIS ? 32'h00AABBCC : 32'h00000000, 0, 2);

    foreach (vecs[i])
      send(vecs[i].rw, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
           vecs[i].rd, vecs[i].err, vecs[i].lat, acc);

    // ---------------- random aligned words and byte lanes ----------------
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      send(1, SIZE_W, 0, B + 32'h100 + 32'(4 * i), model[i], 32'h0, 0, 2, acc);
    end
    for (int j = 0; j < 8; j++) begin
      int k, ln;
      k  = $urandom_range(0, 7);
      ln = $urandom_range(0, 3);
      send(0, SIZE_W, 0, B + 32'h100 + 32'(4 * k), 32'h0, model[k], 0, 2, acc);
      send(0, SIZE_B, 1, B + 32'h100 + 32'(4 * k + ln), 32'h0,
           {24'd0, model[k][8*ln +: 8]}, 0, 2, acc);
    end

    // ---------------- reset during ACCESS0 of a load ----------------
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    send(0, SIZE_W, 0, B + 32'h10, 32'h0, 32'h0, 0, 2, acc);
    void'(exp_q.pop_back());  // abandoned: no response may appear
    @(negedge clock);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("abort_state_access0", {30'd0, dbg_state}, {30'd0, ACCESS0});
    chk("abort_ready_in_reset", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    chk("abort_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    repeat (4) @(negedge clock);

    // ---------------- back-to-back aligned loads, valid held ----------------
    acc_prev = -1;
    for (int i = 0; i < 4; i++) begin
      send(0, SIZE_W, 0, B + 32'h10, 32'h0, 32'h44332211, 0, 2, acc);
      if (i > 0) chk("b2b_accept_spacing", 32'(acc - acc_prev), 32'd2);
      acc_prev = acc;
    end

    @(negedge clock);
    req_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
